// File: rtl/data_memory_stage.sv
// Three-stage data-memory pipeline: DM1 issues word-aligned cache requests, DM2 waits
// for the load response, DM3 extracts/extends load data and picks the write-back value.
module data_memory_stage #(
  parameter int ADDRESS_WIDTH     = 32,
  parameter int REG_ADDRESS_WIDTH = 5
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         STALL_DATA_MEMORY_STAGE,
  input  logic [REG_ADDRESS_WIDTH-1:0] RD_ADDRESS_IN,
  input  logic [ADDRESS_WIDTH-1:0]     ALU_OUT,
  input  logic [2:0]                   DATA_CACHE_LOAD_IN,
  input  logic [1:0]                   DATA_CACHE_STORE_IN,
  input  logic [31:0]                  DATA_CACHE_STORE_DATA_IN,
  input  logic                         WRITE_BACK_MUX_SELECT_IN,
  input  logic                         RD_WRITE_ENABLE_IN,
  output logic [ADDRESS_WIDTH-1:0]     DATA_CACHE_ADDRESS,
  output logic [31:0]                  DATA_CACHE_WRITE_DATA,
  output logic [3:0]                   DATA_CACHE_BYTE_ENABLE,
  output logic                         DATA_CACHE_READ_REQ,
  output logic                         DATA_CACHE_WRITE_REQ,
  input  logic                         DATA_CACHE_READY,
  input  logic [31:0]                  DATA_CACHE_READ_DATA,
  input  logic                         DATA_CACHE_READ_VALID,
  output logic [31:0]                  RD_DATA_DM1,
  output logic [31:0]                  RD_DATA_DM2,
  output logic [31:0]                  RD_DATA_DM3,
  output logic [REG_ADDRESS_WIDTH-1:0] RD_ADDRESS_OUT,
  output logic [31:0]                  RD_DATA_OUT,
  output logic                         RD_WRITE_ENABLE_OUT,
  output logic                         CACHE_STALL,
  output logic                         MISALIGNED_FAULT
);
  localparam logic [2:0] LD_LB = 3'd1, LD_LH = 3'd2, LD_LW = 3'd3, LD_LBU = 3'd4, LD_LHU = 3'd5;
  localparam logic [1:0] ST_SB = 2'd1, ST_SH = 2'd2, ST_SW = 2'd3;

  typedef struct packed {
    logic                         we;
    logic [REG_ADDRESS_WIDTH-1:0] rd;
    logic [ADDRESS_WIDTH-1:0]     alu;
    logic [2:0]                   ld;
    logic                         wb;
  } stage_t;

  stage_t      r_dm1, r_dm2, r_dm3;
  logic [1:0]  r_dm1_st;
  logic [31:0] r_dm1_sd, r_dm1_rdata, r_dm2_rdata, r_dm3_rdata;
  logic        r_dm1_acc, r_dm1_flt, r_dm1_got, r_dm2_pend;

  logic [2:0]  w_in_ld;
  logic [1:0]  w_a;
  logic        w_mis, w_ok, w_req, w_acc, w_hold;
  logic        w_rsp_dm1, w_dm1_have;
  logic [31:0] w_dm1_word, w_dm2_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext, w_final;

  // A store wins over a simultaneous load code; undefined load codes mean no load.
  assign w_in_ld = (DATA_CACHE_STORE_IN != 2'd0 || DATA_CACHE_LOAD_IN > LD_LHU) ? 3'd0 : DATA_CACHE_LOAD_IN;

  assign w_a   = r_dm1.alu[1:0];
  assign w_mis = ((r_dm1.ld == LD_LH || r_dm1.ld == LD_LHU || r_dm1_st == ST_SH) && w_a[0]) ||
                 ((r_dm1.ld == LD_LW || r_dm1_st == ST_SW) && w_a != 2'd0);
  assign w_ok  = (r_dm1.ld != 3'd0 || r_dm1_st != 2'd0) && !w_mis;
  assign w_req = w_ok && !r_dm1_acc && !STALL_DATA_MEMORY_STAGE;
  assign w_acc = w_req && DATA_CACHE_READY;

  assign CACHE_STALL = (w_ok && !r_dm1_acc && !w_acc) || (r_dm2_pend && !DATA_CACHE_READ_VALID);
  assign w_hold      = STALL_DATA_MEMORY_STAGE || CACHE_STALL;

  // Responses are in order: the DM2 load owns it first, else an accepted load still held in DM1.
  assign w_rsp_dm1  = DATA_CACHE_READ_VALID && !r_dm2_pend && r_dm1_acc && r_dm1.ld != 3'd0 && !r_dm1_got;
  assign w_dm1_have = r_dm1_got || w_rsp_dm1;
  assign w_dm1_word = r_dm1_got ? r_dm1_rdata : DATA_CACHE_READ_DATA;
  assign w_dm2_word = r_dm2_pend ? DATA_CACHE_READ_DATA : r_dm2_rdata;

  assign DATA_CACHE_ADDRESS   = {r_dm1.alu[ADDRESS_WIDTH-1:2], 2'b00};
  assign DATA_CACHE_READ_REQ  = w_req && r_dm1.ld != 3'd0;
  assign DATA_CACHE_WRITE_REQ = w_req && r_dm1_st != 2'd0;
  assign MISALIGNED_FAULT     = w_mis && !r_dm1_flt;

  always_comb begin
    DATA_CACHE_BYTE_ENABLE = 4'b0000;
    DATA_CACHE_WRITE_DATA  = r_dm1_sd;
    case (r_dm1_st)
      ST_SB: begin
        DATA_CACHE_BYTE_ENABLE = 4'b0001 << w_a;
        DATA_CACHE_WRITE_DATA  = {4{r_dm1_sd[7:0]}};
      end
      ST_SH: begin
        DATA_CACHE_BYTE_ENABLE = 4'b0011 << {w_a[1], 1'b0};
        DATA_CACHE_WRITE_DATA  = {2{r_dm1_sd[15:0]}};
      end
      ST_SW: DATA_CACHE_BYTE_ENABLE = 4'b1111;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dm1 <= '0; r_dm2 <= '0; r_dm3 <= '0;
      r_dm1_st <= '0; r_dm1_sd <= '0; r_dm1_rdata <= '0; r_dm2_rdata <= '0; r_dm3_rdata <= '0;
      r_dm1_acc <= 1'b0; r_dm1_flt <= 1'b0; r_dm1_got <= 1'b0; r_dm2_pend <= 1'b0;
    end else begin
      if (!w_hold) begin
        r_dm1.we    <= RD_WRITE_ENABLE_IN && RD_ADDRESS_IN != '0;
        r_dm1.rd    <= RD_ADDRESS_IN;
        r_dm1.alu   <= ALU_OUT;
        r_dm1.ld    <= w_in_ld;
        r_dm1.wb    <= WRITE_BACK_MUX_SELECT_IN;
        r_dm1_st    <= DATA_CACHE_STORE_IN;
        r_dm1_sd    <= DATA_CACHE_STORE_DATA_IN;
        r_dm1_acc   <= 1'b0;
        r_dm1_flt   <= 1'b0;
        r_dm1_got   <= 1'b0;
        // A misaligned op continues only as a bubble.
        r_dm2.we    <= r_dm1.we && !w_mis;
        r_dm2.rd    <= r_dm1.rd;
        r_dm2.alu   <= r_dm1.alu;
        r_dm2.ld    <= w_mis ? 3'd0 : r_dm1.ld;
        r_dm2.wb    <= r_dm1.wb;
        r_dm2_pend  <= r_dm1.ld != 3'd0 && !w_mis && !w_dm1_have;
        r_dm2_rdata <= w_dm1_word;
      end else begin
        if (w_acc) r_dm1_acc <= 1'b1;
        if (w_mis) r_dm1_flt <= 1'b1;
        if (w_rsp_dm1) begin
          r_dm1_got   <= 1'b1;
          r_dm1_rdata <= DATA_CACHE_READ_DATA;
        end
        if (r_dm2_pend && DATA_CACHE_READ_VALID) begin
          r_dm2_pend  <= 1'b0;
          r_dm2_rdata <= DATA_CACHE_READ_DATA;
        end
      end
      if (!STALL_DATA_MEMORY_STAGE) begin
        r_dm3       <= CACHE_STALL ? '0 : r_dm2;
        r_dm3_rdata <= CACHE_STALL ? '0 : w_dm2_word;
      end
    end
  end

  assign w_byte = r_dm3_rdata[{r_dm3.alu[1:0], 3'b000} +: 8];
  assign w_half = r_dm3_rdata[{r_dm3.alu[1], 4'b0000} +: 16];

  always_comb begin
    case (r_dm3.ld)
      LD_LB:   w_ext = {{24{w_byte[7]}}, w_byte};
      LD_LH:   w_ext = {{16{w_half[15]}}, w_half};
      LD_LBU:  w_ext = {24'd0, w_byte};
      LD_LHU:  w_ext = {16'd0, w_half};
      default: w_ext = r_dm3_rdata;
    endcase
  end

  assign w_final             = r_dm3.wb ? w_ext : 32'(r_dm3.alu);
  assign RD_DATA_DM1         = 32'(r_dm1.alu);
  assign RD_DATA_DM2         = 32'(r_dm2.alu);
  assign RD_DATA_DM3         = w_final;
  assign RD_DATA_OUT         = w_final;
  assign RD_ADDRESS_OUT      = r_dm3.rd;
  assign RD_WRITE_ENABLE_OUT = r_dm3.we;
endmodule

// File: tb/tb_data_memory_stage.sv
// Bench for data_memory_stage: directed scenarios with literal expectations, then random
// traffic against a slot-level reference model and an in-order cache responder.
module tb_data_memory_stage;
  logic        CLK = 1'b0, RST;
  logic        STALL_DATA_MEMORY_STAGE;
  logic [4:0]  RD_ADDRESS_IN;
  logic [31:0] ALU_OUT;
  logic [2:0]  DATA_CACHE_LOAD_IN;
  logic [1:0]  DATA_CACHE_STORE_IN;
  logic [31:0] DATA_CACHE_STORE_DATA_IN;
  logic        WRITE_BACK_MUX_SELECT_IN, RD_WRITE_ENABLE_IN;
  logic [31:0] DATA_CACHE_ADDRESS, DATA_CACHE_WRITE_DATA;
  logic [3:0]  DATA_CACHE_BYTE_ENABLE;
  logic        DATA_CACHE_READ_REQ, DATA_CACHE_WRITE_REQ, DATA_CACHE_READY;
  logic [31:0] DATA_CACHE_READ_DATA;
  logic        DATA_CACHE_READ_VALID;
  logic [31:0] RD_DATA_DM1, RD_DATA_DM2, RD_DATA_DM3, RD_DATA_OUT;
  logic [4:0]  RD_ADDRESS_OUT;
  logic        RD_WRITE_ENABLE_OUT, CACHE_STALL, MISALIGNED_FAULT;

  data_memory_stage dut (
    .CLK(CLK), .RST(RST), .STALL_DATA_MEMORY_STAGE(STALL_DATA_MEMORY_STAGE),
    .RD_ADDRESS_IN(RD_ADDRESS_IN), .ALU_OUT(ALU_OUT),
    .DATA_CACHE_LOAD_IN(DATA_CACHE_LOAD_IN), .DATA_CACHE_STORE_IN(DATA_CACHE_STORE_IN),
    .DATA_CACHE_STORE_DATA_IN(DATA_CACHE_STORE_DATA_IN),
    .WRITE_BACK_MUX_SELECT_IN(WRITE_BACK_MUX_SELECT_IN), .RD_WRITE_ENABLE_IN(RD_WRITE_ENABLE_IN),
    .DATA_CACHE_ADDRESS(DATA_CACHE_ADDRESS), .DATA_CACHE_WRITE_DATA(DATA_CACHE_WRITE_DATA),
    .DATA_CACHE_BYTE_ENABLE(DATA_CACHE_BYTE_ENABLE), .DATA_CACHE_READ_REQ(DATA_CACHE_READ_REQ),
    .DATA_CACHE_WRITE_REQ(DATA_CACHE_WRITE_REQ), .DATA_CACHE_READY(DATA_CACHE_READY),
    .DATA_CACHE_READ_DATA(DATA_CACHE_READ_DATA), .DATA_CACHE_READ_VALID(DATA_CACHE_READ_VALID),
    .RD_DATA_DM1(RD_DATA_DM1), .RD_DATA_DM2(RD_DATA_DM2), .RD_DATA_DM3(RD_DATA_DM3),
    .RD_ADDRESS_OUT(RD_ADDRESS_OUT), .RD_DATA_OUT(RD_DATA_OUT),
    .RD_WRITE_ENABLE_OUT(RD_WRITE_ENABLE_OUT), .CACHE_STALL(CACHE_STALL),
    .MISALIGNED_FAULT(MISALIGNED_FAULT)
  );

  always #5 CLK = ~CLK;

  // One instruction as the model tracks it while it moves through the three stages.
  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] alu, sd, data;
    logic [2:0]  ld;
    logic [1:0]  st;
    logic        wb, acc, got, flt;
  } slot_t;

  typedef struct { int due; logic [31:0] data; } rsp_t;

  slot_t       m1, m2, m3;
  rsp_t        rq[$];
  int          ncmp = 0, nerr = 0, cyc = 0;
  int          next_delay = 1;
  logic [31:0] next_word = 32'h0;
  bit          rand_mode = 1'b0, drove_q;
  bit          e_ok, e_req, e_rreq, e_wreq, e_cstall, e_fault;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit misal(input slot_t s);
    bit half = (s.ld == 3'd2 || s.ld == 3'd5 || s.st == 2'd2);
    bit word = (s.ld == 3'd3 || s.st == 2'd3);
    return (half && s.alu[0]) || (word && s.alu[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] final_val(input slot_t s);
    logic [7:0]  b = 8'(s.data >> (8 * s.alu[1:0]));
    logic [15:0] h = 16'(s.data >> (s.alu[1] ? 16 : 0));
    if (!s.wb) return s.alu;
    case (s.ld)
      3'd1:    return 32'($signed(b));
      3'd2:    return 32'($signed(h));
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return s.data;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input slot_t s);
    case (s.st)
      2'd1:    return 4'(1 << s.alu[1:0]);
      2'd2:    return s.alu[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] exp_wd(input slot_t s);
    case (s.st)
      2'd1:    return {4{s.sd[7:0]}};
      2'd2:    return {2{s.sd[15:0]}};
      default: return s.sd;
    endcase
  endfunction

  task automatic set_op(input logic [2:0] ld, input logic [1:0] st, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] sd, input logic wb, input logic we);
    DATA_CACHE_LOAD_IN = ld; DATA_CACHE_STORE_IN = st; RD_ADDRESS_IN = rd; ALU_OUT = alu;
    DATA_CACHE_STORE_DATA_IN = sd; WRITE_BACK_MUX_SELECT_IN = wb; RD_WRITE_ENABLE_IN = we;
  endtask

  task automatic nop();
    set_op(3'd0, 2'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // Drive the cache response for this cycle, then check every output against the model.
  task automatic prep();
    drove_q = 1'b0;
    DATA_CACHE_READ_VALID = 1'b0;
    DATA_CACHE_READ_DATA  = $urandom;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      DATA_CACHE_READ_VALID = 1'b1;
      DATA_CACHE_READ_DATA  = rq[0].data;
      drove_q = 1'b1;
    end else if (rand_mode && rq.size() == 0 && $urandom_range(0, 9) == 0) begin
      DATA_CACHE_READ_VALID = 1'b1;
    end
    #1;
    e_ok     = (m1.ld != 0 || m1.st != 0) && !misal(m1);
    e_req    = e_ok && !m1.acc && !STALL_DATA_MEMORY_STAGE;
    e_rreq   = e_req && m1.ld != 0;
    e_wreq   = e_req && m1.st != 0;
    e_cstall = (e_ok && !m1.acc && !(e_req && DATA_CACHE_READY)) ||
               (m2.ld != 0 && !m2.got && !DATA_CACHE_READ_VALID);
    e_fault  = misal(m1) && !m1.flt;
    chk("cache_stall", 32'(CACHE_STALL), 32'(e_cstall));
    chk("misaligned_fault", 32'(MISALIGNED_FAULT), 32'(e_fault));
    chk("read_req", 32'(DATA_CACHE_READ_REQ), 32'(e_rreq));
    chk("write_req", 32'(DATA_CACHE_WRITE_REQ), 32'(e_wreq));
    if (e_req) chk("cache_address", DATA_CACHE_ADDRESS, {m1.alu[31:2], 2'b00});
    if (e_wreq) begin
      chk("byte_enable", 32'(DATA_CACHE_BYTE_ENABLE), 32'(exp_be(m1)));
      chk("write_data", DATA_CACHE_WRITE_DATA, exp_wd(m1));
    end
    chk("rd_data_dm1", RD_DATA_DM1, m1.alu);
    chk("rd_data_dm2", RD_DATA_DM2, m2.alu);
    chk("rd_we_out", 32'(RD_WRITE_ENABLE_OUT), 32'(m3.we));
    if (m3.we) begin
      chk("rd_addr_out", 32'(RD_ADDRESS_OUT), 32'(m3.rd));
      chk("rd_data_out", RD_DATA_OUT, final_val(m3));
      chk("rd_data_dm3", RD_DATA_DM3, final_val(m3));
    end
  endtask

  // Advance the model and the cache responder over the coming edge, then take the edge.
  task automatic adv();
    slot_t n;
    if (drove_q) void'(rq.pop_front());
    if (RST) begin
      m1 = '0; m2 = '0; m3 = '0;
    end else begin
      if (e_rreq && DATA_CACHE_READY)
        rq.push_back('{due: cyc + (rand_mode ? $urandom_range(1, 4) : next_delay),
                       data: rand_mode ? $urandom : next_word});
      if (DATA_CACHE_READ_VALID) begin
        if (m2.ld != 0 && !m2.got) begin m2.got = 1'b1; m2.data = DATA_CACHE_READ_DATA; end
        else if (m1.ld != 0 && m1.acc && !m1.got) begin m1.got = 1'b1; m1.data = DATA_CACHE_READ_DATA; end
      end
      if (e_req && DATA_CACHE_READY) m1.acc = 1'b1;
      if (!STALL_DATA_MEMORY_STAGE) m3 = e_cstall ? '0 : m2;
      if (!STALL_DATA_MEMORY_STAGE && !e_cstall) begin
        m2 = m1;
        if (misal(m1)) begin m2.we = 1'b0; m2.ld = 3'd0; m2.st = 2'd0; end
        n = '0;
        n.st = DATA_CACHE_STORE_IN;
        n.ld = (n.st != 0 || DATA_CACHE_LOAD_IN > 3'd5) ? 3'd0 : DATA_CACHE_LOAD_IN;
        n.rd = RD_ADDRESS_IN; n.alu = ALU_OUT; n.sd = DATA_CACHE_STORE_DATA_IN;
        n.wb = WRITE_BACK_MUX_SELECT_IN; n.we = RD_WRITE_ENABLE_IN && RD_ADDRESS_IN != 0;
        m1 = n;
      end else if (misal(m1)) m1.flt = 1'b1;
    end
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
  endtask

  task automatic cyc1();
    prep(); adv();
  endtask

  task automatic load_test(input logic [2:0] ld, input logic [31:0] exp, input string name);
    int stalls = 0;
    bit seen = 1'b0;
    logic [31:0] val = 32'h0;
    next_word = 32'h0080FF00; next_delay = 4;
    set_op(ld, 2'd0, 5'd7, 32'h2002, 32'h0, 1'b1, 1'b1);
    cyc1();
    nop();
    for (int i = 0; i < 10; i++) begin
      prep();
      if (CACHE_STALL) stalls++;
      if (RD_WRITE_ENABLE_OUT && RD_ADDRESS_OUT == 5'd7 && !seen) begin seen = 1'b1; val = RD_DATA_OUT; end
      adv();
    end
    chk({name, "_stall_cycles"}, 32'(stalls), 32'd3);
    chk({name, "_written"}, 32'(seen), 32'd1);
    chk({name, "_data"}, val, exp);
  endtask

  initial begin
    int nacc, nwe;
    logic [31:0] a;
    logic [2:0]  ld;
    logic [1:0]  st;
    RST = 1'b1; STALL_DATA_MEMORY_STAGE = 1'b0; DATA_CACHE_READY = 1'b1;
    DATA_CACHE_READ_VALID = 1'b0; DATA_CACHE_READ_DATA = 32'h0;
    nop();
    m1 = '0; m2 = '0; m3 = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // Reset state
    #1;
    chk("reset_cache_stall", 32'(CACHE_STALL), 32'd0);
    chk("reset_read_req", 32'(DATA_CACHE_READ_REQ), 32'd0);
    chk("reset_write_req", 32'(DATA_CACHE_WRITE_REQ), 32'd0);
    chk("reset_we_out", 32'(RD_WRITE_ENABLE_OUT), 32'd0);
    chk("reset_rd_data_out", RD_DATA_OUT, 32'd0);

    // ALU result forwarding and three-edge latency
    set_op(3'd0, 2'd0, 5'd5, 32'h1234, 32'h0, 1'b0, 1'b1);
    cyc1();
    nop();
    prep(); chk("t1_dm1", RD_DATA_DM1, 32'h1234); adv();
    cyc1();
    prep();
    chk("t1_data_out", RD_DATA_OUT, 32'h1234);
    chk("t1_we_out", 32'(RD_WRITE_ENABLE_OUT), 32'd1);
    chk("t1_rd_out", 32'(RD_ADDRESS_OUT), 32'd5);
    adv();

    // SB to byte 3
    set_op(3'd0, 2'd1, 5'd0, 32'h1003, 32'h000000AB, 1'b0, 1'b0);
    cyc1();
    nop();
    prep();
    chk("t2_addr", DATA_CACHE_ADDRESS, 32'h1000);
    chk("t2_be", 32'(DATA_CACHE_BYTE_ENABLE), 32'h8);
    chk("t2_wdata", DATA_CACHE_WRITE_DATA, 32'hABABABAB);
    chk("t2_wreq", 32'(DATA_CACHE_WRITE_REQ), 32'd1);
    adv();
    prep(); chk("t2_wreq_once", 32'(DATA_CACHE_WRITE_REQ), 32'd0); adv();

    // Loads with a late response
    load_test(3'd1, 32'hFFFFFF80, "t3_lb");
    load_test(3'd4, 32'h00000080, "t3_lbu");

    // Misaligned LW
    set_op(3'd3, 2'd0, 5'd9, 32'h3002, 32'h0, 1'b1, 1'b1);
    cyc1();
    nop();
    prep();
    chk("t4_no_rreq", 32'(DATA_CACHE_READ_REQ), 32'd0);
    chk("t4_fault", 32'(MISALIGNED_FAULT), 32'd1);
    adv();
    prep(); chk("t4_fault_once", 32'(MISALIGNED_FAULT), 32'd0); adv();
    prep(); chk("t4_we_out", 32'(RD_WRITE_ENABLE_OUT), 32'd0); adv();

    // SW held by READY=0 for two cycles behind an ALU op
    set_op(3'd0, 2'd0, 5'd3, 32'h55, 32'h0, 1'b0, 1'b1);
    cyc1();
    set_op(3'd0, 2'd3, 5'd0, 32'h4000, 32'h11223344, 1'b0, 1'b0);
    cyc1();
    nop();
    DATA_CACHE_READY = 1'b0;
    nacc = 0;
    prep();
    chk("t5_wreq", 32'(DATA_CACHE_WRITE_REQ), 32'd1);
    chk("t5_stall", 32'(CACHE_STALL), 32'd1);
    adv();
    prep();
    chk("t5_dm2_held", RD_DATA_DM2, 32'h55);
    chk("t5_dm3_bubble", 32'(RD_WRITE_ENABLE_OUT), 32'd0);
    adv();
    DATA_CACHE_READY = 1'b1;
    prep(); nacc += int'(DATA_CACHE_WRITE_REQ && DATA_CACHE_READY); adv();
    prep();
    chk("t5_we_out", 32'(RD_WRITE_ENABLE_OUT), 32'd1);
    chk("t5_rd_out", 32'(RD_ADDRESS_OUT), 32'd3);
    chk("t5_data_out", RD_DATA_OUT, 32'h55);
    nacc += int'(DATA_CACHE_WRITE_REQ && DATA_CACHE_READY);
    adv();
    repeat (2) begin prep(); nacc += int'(DATA_CACHE_WRITE_REQ && DATA_CACHE_READY); adv(); end
    chk("t5_single_accept", 32'(nacc), 32'd1);

    // Reset while a load waits for its response
    next_delay = 6; next_word = 32'hDEADBEEF;
    set_op(3'd3, 2'd0, 5'd4, 32'h5000, 32'h0, 1'b1, 1'b1);
    cyc1();
    nop();
    cyc1();
    cyc1();
    RST = 1'b1;
    cyc1();
    RST = 1'b0;
    prep();
    chk("t6_stall", 32'(CACHE_STALL), 32'd0);
    chk("t6_rreq", 32'(DATA_CACHE_READ_REQ), 32'd0);
    chk("t6_we_out", 32'(RD_WRITE_ENABLE_OUT), 32'd0);
    chk("t6_dm1", RD_DATA_DM1, 32'd0);
    adv();
    nwe = 0;
    repeat (8) begin prep(); nwe += int'(RD_WRITE_ENABLE_OUT); adv(); end
    chk("t6_late_valid_ignored", 32'(nwe), 32'd0);

    // Random traffic
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      ld = 3'($urandom_range(0, 7));
      st = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      set_op(ld, st, 5'($urandom_range(0, 31)), a, $urandom,
             (st == 2'd0 && ld >= 3'd1 && ld <= 3'd5) ? 1'b1 : 1'b0, $urandom_range(0, 3) != 0);
      STALL_DATA_MEMORY_STAGE = ($urandom_range(0, 4) == 0);
      DATA_CACHE_READY = ($urandom_range(0, 9) < 7);
      cyc1();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
